// File: rtl/logic_reduce_fifo.sv
// Bitwise OR/AND/XOR/NOR reduction over N_IN operands feeding a DEPTH-entry result FIFO.
// Optional push statistics output stat_cnt enabled by defining LOGIC_REDUCE_STAT_EN.
module logic_reduce_fifo #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 2,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_IN*WIDTH-1:0]     in_data,
  input  logic [1:0]                op,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
`ifdef LOGIC_REDUCE_STAT_EN
  output logic [31:0]               stat_cnt,
`endif
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] or_acc  [N_IN];
  logic [WIDTH-1:0] and_acc [N_IN];
  logic [WIDTH-1:0] xor_acc [N_IN];
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push;
  logic             pop;

  // Running partial reductions; the last stage holds the full result.
  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_reduce
      if (gi == 0) begin : g_first
        assign or_acc[gi]  = in_data[0 +: WIDTH];
        assign and_acc[gi] = in_data[0 +: WIDTH];
        assign xor_acc[gi] = in_data[0 +: WIDTH];
      end else begin : g_next
        assign or_acc[gi]  = or_acc[gi-1]  | in_data[gi*WIDTH +: WIDTH];
        assign and_acc[gi] = and_acc[gi-1] & in_data[gi*WIDTH +: WIDTH];
        assign xor_acc[gi] = xor_acc[gi-1] ^ in_data[gi*WIDTH +: WIDTH];
      end
    end
  endgenerate

  always_comb begin
    result = or_acc[N_IN-1];
    case (op)
      2'b00:   result = or_acc[N_IN-1];
      2'b01:   result = and_acc[N_IN-1];
      2'b10:   result = xor_acc[N_IN-1];
      default: result = ~or_acc[N_IN-1];
    endcase
  end

  // in_ready depends only on registered count, so a pop never frees a slot in the same cycle.
  assign in_ready  = (count_reg != FULL_COUNT);
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr_reg];
  assign count     = count_reg;

  always_ff @(posedge clk) begin
    if (push && rst_n) begin
      mem[wr_ptr_reg] <= result;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef LOGIC_REDUCE_STAT_EN
  logic [31:0] stat_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_reg <= '0;
    end else if (push) begin
      stat_reg <= stat_reg + 32'd1;
    end
  end

  assign stat_cnt = stat_reg;
`endif

endmodule

// File: tb/tb_logic_reduce_fifo.sv
// Directed self-checking bench for logic_reduce_fifo (defaults; N_IN=4 instance when stats enabled).
module tb_logic_reduce_fifo;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  count;
  int          pass_cnt;
  int          check_cnt;

`ifdef LOGIC_REDUCE_STAT_EN
  logic [31:0] stat_cnt;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [31:0] s_in_data;
  logic [1:0]  s_op;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [7:0]  s_out_data;
  logic [2:0]  s_count;
  logic [31:0] s_stat_cnt;
`endif

  logic_reduce_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef LOGIC_REDUCE_STAT_EN
    .stat_cnt  (stat_cnt),
`endif
    .count     (count)
  );

`ifdef LOGIC_REDUCE_STAT_EN
  logic_reduce_fifo #(.WIDTH(8), .N_IN(4), .DEPTH(4)) dut_stat (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .op        (s_op),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .stat_cnt  (s_stat_cnt),
    .count     (s_count)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check_cnt++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_state: count=%0d out_valid=%b in_ready=%b, required 0/0/1", count, out_valid, in_ready);
    else pass_cnt++;
    $display("reset: count=%0d out_valid=%b in_ready=%b", count, out_valid, in_ready);
  endtask

  task automatic test_op_sweep();
    logic [7:0] exp_tab [4];
    exp_tab[0] = 8'hFF; exp_tab[1] = 8'h00; exp_tab[2] = 8'hFF; exp_tab[3] = 8'h00;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'hF00F;
      op       = 2'(i);
      step();
      in_valid = 1'b0;
      in_data  = 16'h1234;
      check_cnt++;
      if (out_valid !== 1'b1 || out_data !== exp_tab[i])
        $display("FAIL op_sweep_%0d: out_valid=%b out_data=%h, required 1/%h", i, out_valid, out_data, exp_tab[i]);
      else pass_cnt++;
      $display("op=%0d in_data=F00F -> out_data=%h", i, out_data);
      step();
      check_cnt++;
      if (out_valid !== 1'b0 || count !== 3'd0)
        $display("FAIL op_sweep_drain_%0d: out_valid=%b count=%0d, required 0/0", i, out_valid, count);
      else pass_cnt++;
    end
  endtask

  task automatic test_fill_and_pop_on_full();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    out_ready = 1'b0;
    op        = 2'b00;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = {8'h00, vals[i]};
      step();
      $display("fill push %h: count=%0d", vals[i], count);
    end
    check_cnt++;
    if (count !== 3'd4 || in_ready !== 1'b0)
      $display("FAIL fill_full: count=%0d in_ready=%b, required 4/0", count, in_ready);
    else pass_cnt++;
    in_data = 16'h0055;
    step();
    check_cnt++;
    if (count !== 3'd4 || in_ready !== 1'b0 || out_data !== 8'h11)
      $display("FAIL fill_fifth_rejected: count=%0d in_ready=%b out_data=%h, required 4/0/11", count, in_ready, out_data);
    else pass_cnt++;
    $display("fifth push attempt: count=%0d head=%h", count, out_data);
    in_data   = 16'h0066;
    out_ready = 1'b1;
    step();
    check_cnt++;
    if (count !== 3'd3 || in_ready !== 1'b1 || out_data !== 8'h22)
      $display("FAIL pop_on_full: count=%0d in_ready=%b out_data=%h, required 3/1/22", count, in_ready, out_data);
    else pass_cnt++;
    $display("pop on full: count=%0d head=%h", count, out_data);
    in_valid = 1'b0;
    for (int i = 2; i < 4; i++) begin
      step();
      check_cnt++;
      if (out_valid !== 1'b1 || out_data !== vals[i])
        $display("FAIL pop_order_%0d: out_valid=%b out_data=%h, required 1/%h", i, out_valid, out_data, vals[i]);
      else pass_cnt++;
      $display("pop: head=%h count=%0d", out_data, count);
    end
    step();
    check_cnt++;
    if (count !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL pop_drained: count=%0d out_valid=%b, required 0/0", count, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] src [10];
    logic [7:0] exp_tab [10];
    src[0] = 8'h00; src[1] = 8'h11; src[2] = 8'h22; src[3] = 8'h33; src[4] = 8'h44;
    src[5] = 8'h55; src[6] = 8'h66; src[7] = 8'h77; src[8] = 8'h88; src[9] = 8'h99;
    exp_tab[0] = 8'h0F; exp_tab[1] = 8'h1E; exp_tab[2] = 8'h2D; exp_tab[3] = 8'h3C; exp_tab[4] = 8'h4B;
    exp_tab[5] = 8'h5A; exp_tab[6] = 8'h69; exp_tab[7] = 8'h78; exp_tab[8] = 8'h87; exp_tab[9] = 8'h96;
    out_ready = 1'b1;
    op        = 2'b10;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = {8'h0F, src[i]};
      step();
      check_cnt++;
      if (out_valid !== 1'b1 || out_data !== exp_tab[i] || count !== 3'd1)
        $display("FAIL stream_%0d: out_valid=%b out_data=%h count=%0d, required 1/%h/1", i, out_valid, out_data, count, exp_tab[i]);
      else pass_cnt++;
      $display("stream %0d: out_data=%h count=%0d", i, out_data, count);
    end
    in_valid = 1'b0;
    step();
    check_cnt++;
    if (count !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL stream_drained: count=%0d out_valid=%b, required 0/0", count, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    out_ready = 1'b0;
    op        = 2'b00;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = {8'h00, 8'hA1 + 8'(i)};
      step();
    end
    check_cnt++;
    if (count !== 3'd3)
      $display("FAIL mid_reset_prefill: count=%0d, required 3", count);
    else pass_cnt++;
    rst_n     = 1'b0;
    in_data   = 16'h00EE;
    out_ready = 1'b1;
    step();
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_cnt++;
    if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1)
      $display("FAIL mid_reset_clear: out_valid=%b count=%0d in_ready=%b, required 0/0/1", out_valid, count, in_ready);
    else pass_cnt++;
    $display("mid-op reset: count=%0d out_valid=%b", count, out_valid);
    in_valid = 1'b1;
    in_data  = 16'h005C;
    step();
    in_valid = 1'b0;
    check_cnt++;
    if (count !== 3'd1 || out_data !== 8'h5C)
      $display("FAIL mid_reset_new_push: count=%0d out_data=%h, required 1/5c", count, out_data);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    check_cnt++;
    if (count !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL mid_reset_only_new: count=%0d out_valid=%b, required 0/0", count, out_valid);
    else pass_cnt++;
    $display("post-reset push 5c popped: count=%0d", count);
  endtask

`ifdef LOGIC_REDUCE_STAT_EN
  task automatic test_stats();
    s_out_ready = 1'b1;
    s_op        = 2'b01;
    for (int i = 0; i < 7; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = 32'hFFFF_FFFF;
      step();
    end
    s_in_valid = 1'b0;
    step();
    check_cnt++;
    if (s_stat_cnt !== 32'd7)
      $display("FAIL stat_count: stat_cnt=%0d, required 7", s_stat_cnt);
    else pass_cnt++;
    $display("stats: stat_cnt=%0d", s_stat_cnt);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_cnt++;
    if (s_stat_cnt !== 32'd0)
      $display("FAIL stat_reset: stat_cnt=%0d, required 0", s_stat_cnt);
    else pass_cnt++;
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    check_cnt = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    op        = 2'b00;
    out_ready = 1'b0;
`ifdef LOGIC_REDUCE_STAT_EN
    s_in_valid  = 1'b0;
    s_in_data   = '0;
    s_op        = 2'b00;
    s_out_ready = 1'b0;
`endif
    test_reset();
    test_op_sweep();
    test_fill_and_pop_on_full();
    test_back_to_back();
    test_reset_mid_op();
`ifdef LOGIC_REDUCE_STAT_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
